alu_issue_sched: RTL and testbench

- Out-of-order issue queue and select logic feeding the single `execute_alu` instance.
- Buffers renamed ALU/branch uops until both source operands are available. Operand data is captured from writeback broadcasts.
- Each cycle, launches the oldest ready entry into a registered issue stage that drives the ALU inputs.
- Sits between rename/dispatch and `execute_alu`. Flushed on branch mispredict.

---
 rtl/decode_pkg.sv | 18 +
 rtl/alu_issue_sched.sv | 216 +++++++++++++++++++++
 tb/tb_alu_issue_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Decoded micro-op payload shared by dispatch, issue and the ALU.
// Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

    // Payload carried unchanged from dispatch to execute_alu
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        is_branch;
        logic        use_imm;
        logic [31:0] imm;
    } uop_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched
// Description : Collapsing out-of-order issue queue with oldest-ready select,
//               writeback wakeup/capture and a registered issue stage that
//               feeds execute_alu.
// Revision    : 1.0  initial release
// ============================================================================
module alu_issue_sched #(
    parameter int DEPTH    = 8,
    parameter int TAG_W    = 6,
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    // dispatch side
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  decode_pkg::uop_t             enq_uop_i,
    input  logic [TAG_W-1:0]             enq_rob_tag_i,
    input  logic                         enq_rs1_ready_i,
    input  logic                         enq_rs2_ready_i,
    input  logic [TAG_W-1:0]             enq_rs1_tag_i,
    input  logic [TAG_W-1:0]             enq_rs2_tag_i,
    input  logic [XLEN-1:0]              enq_rs1_data_i,
    input  logic [XLEN-1:0]              enq_rs2_data_i,
    // writeback broadcast
    input  logic [WB_PORTS-1:0]          wb_valid_i,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag_i,
    input  logic [WB_PORTS*XLEN-1:0]     wb_data_i,
    // control
    input  logic                         flush_i,
    input  logic                         issue_ready_i,
    // issue stage
    output logic                         issue_valid_o,
    output decode_pkg::uop_t             issue_uop_o,
    output logic [XLEN-1:0]              issue_rs1_data_o,
    output logic [XLEN-1:0]              issue_rs2_data_o,
    output logic [TAG_W-1:0]             issue_rob_tag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        decode_pkg::uop_t uop;
        logic [TAG_W-1:0] rob_tag;
        logic             rs1_ready;
        logic [TAG_W-1:0] rs1_tag;
        logic [XLEN-1:0]  rs1_data;
        logic             rs2_ready;
        logic [TAG_W-1:0] rs2_tag;
        logic [XLEN-1:0]  rs2_data;
    } entry_t;

    // Queue storage and its next state
    entry_t                r_entries [DEPTH];
    entry_t                w_next    [DEPTH];
    entry_t                w_enq_entry;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_CNT_W-1:0]    w_wr_idx;

    // Select / handshake
    logic                  w_sel_found;
    logic [c_IDX_W-1:0]    w_sel_idx;
    logic                  w_issue_load;
    logic                  w_enq_fire;

    // Issue stage registers
    logic                  r_issue_valid;
    decode_pkg::uop_t      r_issue_uop;
    logic [XLEN-1:0]       r_issue_rs1_data;
    logic [XLEN-1:0]       r_issue_rs2_data;
    logic [TAG_W-1:0]      r_issue_rob_tag;

    // Returns {ready, data} for one operand after looking at the writeback
    // ports. Ports are scanned high to low so the lowest matching port wins.
    function automatic logic [XLEN:0] f_wake(
        input logic                      rdy,
        input logic [TAG_W-1:0]          tag,
        input logic [XLEN-1:0]           data,
        input logic [WB_PORTS-1:0]       wb_valid,
        input logic [WB_PORTS*TAG_W-1:0] wb_tag,
        input logic [WB_PORTS*XLEN-1:0]  wb_data
    );
        logic [XLEN:0] res;
        res = {rdy, data};
        if (!rdy) begin
            for (int p = WB_PORTS-1; p >= 0; p--) begin
                if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == tag)) begin
                    res = {1'b1, wb_data[p*XLEN +: XLEN]};
                end
            end
        end
        return res;
    endfunction

    // Handshake: ready looks only at the registered count, so an issue in
    // the same cycle never gives credit to a full queue.
    always_comb begin
        enq_ready_o  = (r_count < c_CNT_W'(DEPTH));
        w_enq_fire   = enq_valid_i && enq_ready_o && !flush_i;
        w_issue_load = w_sel_found && (!r_issue_valid || issue_ready_i) && !flush_i;
        w_wr_idx     = w_issue_load ? (r_count - 1'b1) : r_count;
    end

    // Oldest-ready select: lowest slot with both operands available
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_sel_found && r_entries[i].valid &&
                r_entries[i].rs1_ready && r_entries[i].rs2_ready) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IDX_W'(i);
            end
        end
    end

    // Incoming entry, with same-cycle writeback bypass on waiting operands
    always_comb begin
        w_enq_entry         = '0;
        w_enq_entry.valid   = 1'b1;
        w_enq_entry.uop     = enq_uop_i;
        w_enq_entry.rob_tag = enq_rob_tag_i;
        w_enq_entry.rs1_tag = enq_rs1_tag_i;
        w_enq_entry.rs2_tag = enq_rs2_tag_i;
        {w_enq_entry.rs1_ready, w_enq_entry.rs1_data} =
            f_wake(enq_rs1_ready_i, enq_rs1_tag_i, enq_rs1_data_i,
                   wb_valid_i, wb_tag_i, wb_data_i);
        {w_enq_entry.rs2_ready, w_enq_entry.rs2_data} =
            f_wake(enq_rs2_ready_i, enq_rs2_tag_i, enq_rs2_data_i,
                   wb_valid_i, wb_tag_i, wb_data_i);
    end

    // Collapse above the issued slot, wake entries in their new position,
    // then drop the incoming uop into the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue_load && (i >= int'(w_sel_idx))) begin
                w_next[i] = r_entries[(i < DEPTH-1) ? i+1 : i];
                if (i == DEPTH-1) begin
                    w_next[i].valid = 1'b0;
                end
            end else begin
                w_next[i] = r_entries[i];
            end

            if (w_next[i].valid) begin
                {w_next[i].rs1_ready, w_next[i].rs1_data} =
                    f_wake(w_next[i].rs1_ready, w_next[i].rs1_tag, w_next[i].rs1_data,
                           wb_valid_i, wb_tag_i, wb_data_i);
                {w_next[i].rs2_ready, w_next[i].rs2_data} =
                    f_wake(w_next[i].rs2_ready, w_next[i].rs2_tag, w_next[i].rs2_data,
                           wb_valid_i, wb_tag_i, wb_data_i);
            end

            if (w_enq_fire && (w_wr_idx == c_CNT_W'(i))) begin
                w_next[i] = w_enq_entry;
            end
        end
    end

    // Queue state: reset and flush discard every entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= w_next[i];
            end
            r_count <= r_count + c_CNT_W'(w_enq_fire) - c_CNT_W'(w_issue_load);
        end
    end

    // Issue stage: load the selected entry, clear on consume, else hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_issue_valid    <= 1'b0;
            r_issue_uop      <= '0;
            r_issue_rs1_data <= '0;
            r_issue_rs2_data <= '0;
            r_issue_rob_tag  <= '0;
        end else if (flush_i) begin
            r_issue_valid    <= 1'b0;
        end else if (w_issue_load) begin
            r_issue_valid    <= 1'b1;
            r_issue_uop      <= r_entries[w_sel_idx].uop;
            r_issue_rs1_data <= r_entries[w_sel_idx].rs1_data;
            r_issue_rs2_data <= r_entries[w_sel_idx].rs2_data;
            r_issue_rob_tag  <= r_entries[w_sel_idx].rob_tag;
        end else if (issue_ready_i && r_issue_valid) begin
            r_issue_valid    <= 1'b0;
        end
    end

    assign issue_valid_o    = r_issue_valid;
    assign issue_uop_o      = r_issue_uop;
    assign issue_rs1_data_o = r_issue_rs1_data;
    assign issue_rs2_data_o = r_issue_rs2_data;
    assign issue_rob_tag_o  = r_issue_rob_tag;
    assign count_o          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_sched
// Description : Directed self-checking bench for alu_issue_sched.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_sched;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             enq_valid_i = 1'b0;
    logic             enq_ready_o;
    decode_pkg::uop_t enq_uop_i = '0;
    logic [5:0]       enq_rob_tag_i = '0;
    logic             enq_rs1_ready_i = 1'b0;
    logic             enq_rs2_ready_i = 1'b0;
    logic [5:0]       enq_rs1_tag_i = '0;
    logic [5:0]       enq_rs2_tag_i = '0;
    logic [31:0]      enq_rs1_data_i = '0;
    logic [31:0]      enq_rs2_data_i = '0;
    logic [1:0]       wb_valid_i = '0;
    logic [11:0]      wb_tag_i = '0;
    logic [63:0]      wb_data_i = '0;
    logic             flush_i = 1'b0;
    logic             issue_ready_i = 1'b0;
    logic             issue_valid_o;
    decode_pkg::uop_t issue_uop_o;
    logic [31:0]      issue_rs1_data_o;
    logic [31:0]      issue_rs2_data_o;
    logic [5:0]       issue_rob_tag_o;
    logic [3:0]       count_o;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_sched #(.DEPTH(8), .TAG_W(6), .XLEN(32), .WB_PORTS(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .enq_valid_i      (enq_valid_i),
        .enq_ready_o      (enq_ready_o),
        .enq_uop_i        (enq_uop_i),
        .enq_rob_tag_i    (enq_rob_tag_i),
        .enq_rs1_ready_i  (enq_rs1_ready_i),
        .enq_rs2_ready_i  (enq_rs2_ready_i),
        .enq_rs1_tag_i    (enq_rs1_tag_i),
        .enq_rs2_tag_i    (enq_rs2_tag_i),
        .enq_rs1_data_i   (enq_rs1_data_i),
        .enq_rs2_data_i   (enq_rs2_data_i),
        .wb_valid_i       (wb_valid_i),
        .wb_tag_i         (wb_tag_i),
        .wb_data_i        (wb_data_i),
        .flush_i          (flush_i),
        .issue_ready_i    (issue_ready_i),
        .issue_valid_o    (issue_valid_o),
        .issue_uop_o      (issue_uop_o),
        .issue_rs1_data_o (issue_rs1_data_o),
        .issue_rs2_data_o (issue_rs2_data_o),
        .issue_rob_tag_o  (issue_rob_tag_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [5:0] rob,
                       input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                       input logic r2, input logic [5:0] t2, input logic [31:0] d2);
        enq_valid_i         = 1'b1;
        enq_rob_tag_i       = rob;
        enq_uop_i           = '0;
        enq_uop_i.alu_op    = rob[3:0];
        enq_uop_i.imm       = {26'd0, rob};
        enq_rs1_ready_i     = r1;
        enq_rs1_tag_i       = t1;
        enq_rs1_data_i      = d1;
        enq_rs2_ready_i     = r2;
        enq_rs2_tag_i       = t2;
        enq_rs2_data_i      = d2;
    endtask

    task automatic enq_off();
        enq_valid_i = 1'b0;
    endtask

    task automatic wb(input logic [1:0] v, input logic [5:0] t0, input logic [31:0] d0,
                      input logic [5:0] t1, input logic [31:0] d1);
        wb_valid_i = v;
        wb_tag_i   = {t1, t0};
        wb_data_i  = {d1, d0};
    endtask

    initial begin
        // ---------------- reset values ----------------
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
        check("rst_issue_valid", 64'(issue_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_rob_tag", 64'(issue_rob_tag_o), 64'd0);
        check("rst_rs1", 64'(issue_rs1_data_o), 64'd0);
        check("rst_rs2", 64'(issue_rs2_data_o), 64'd0);
        check("rst_uop_imm", 64'(issue_uop_o.imm), 64'd0);

        // ---------------- basic two-cycle latency ----------------
        issue_ready_i = 1'b1;
        enq(6'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);          // cycle 0
        tick(); enq_off();                                         // cycle 1
        check("basic_count_c1", 64'(count_o), 64'd1);
        check("basic_valid_c1", 64'(issue_valid_o), 64'd0);
        tick();                                                    // cycle 2
        check("basic_valid_c2", 64'(issue_valid_o), 64'd1);
        check("basic_rob_c2", 64'(issue_rob_tag_o), 64'd3);
        check("basic_rs1_c2", 64'(issue_rs1_data_o), 64'd5);
        check("basic_rs2_c2", 64'(issue_rs2_data_o), 64'd7);
        check("basic_uop_c2", 64'(issue_uop_o.imm), 64'd3);
        check("basic_count_c2", 64'(count_o), 64'd0);
        tick();                                                    // cycle 3
        check("basic_consumed", 64'(issue_valid_o), 64'd0);

        // ---------------- ordering and wakeup ----------------
        enq(6'd1, 1'b1, 6'd0, 32'h11, 1'b0, 6'd9, 32'h0);         // cycle 0: A waits on tag 9
        tick();
        enq(6'd2, 1'b1, 6'd0, 32'h22, 1'b1, 6'd0, 32'h33);        // cycle 1: B ready
        tick(); enq_off();                                         // cycle 2
        check("order_count_c2", 64'(count_o), 64'd2);
        check("order_valid_c2", 64'(issue_valid_o), 64'd0);
        tick();                                                    // cycle 3: B issues
        check("order_valid_c3", 64'(issue_valid_o), 64'd1);
        check("order_rob_c3", 64'(issue_rob_tag_o), 64'd2);
        check("order_count_c3", 64'(count_o), 64'd1);
        tick();                                                    // cycle 4
        check("order_valid_c4", 64'(issue_valid_o), 64'd0);
        tick();                                                    // cycle 5: broadcast
        wb(2'b10, 6'd9, 32'hBB, 6'd9, 32'hAA);                     // port0 tag matches but invalid
        tick(); wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);               // cycle 6
        check("wake_valid_c6", 64'(issue_valid_o), 64'd0);
        check("wake_count_c6", 64'(count_o), 64'd1);
        tick();                                                    // cycle 7: A issues
        check("wake_valid_c7", 64'(issue_valid_o), 64'd1);
        check("wake_rob_c7", 64'(issue_rob_tag_o), 64'd1);
        check("wake_rs1_c7", 64'(issue_rs1_data_o), 64'h11);
        check("wake_rs2_c7", 64'(issue_rs2_data_o), 64'hAA);
        check("wake_count_c7", 64'(count_o), 64'd0);
        tick();

        // ---------------- oldest first, back to back ----------------
        enq(6'd4, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd0);
        tick();
        enq(6'd5, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd0);
        tick();
        enq(6'd6, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd0);
        check("oldest_rob4", 64'(issue_rob_tag_o), 64'd4);
        check("oldest_valid4", 64'(issue_valid_o), 64'd1);
        tick(); enq_off();
        check("oldest_rob5", 64'(issue_rob_tag_o), 64'd5);
        tick();
        check("oldest_rob6", 64'(issue_rob_tag_o), 64'd6);
        check("oldest_valid6", 64'(issue_valid_o), 64'd1);
        tick();
        check("oldest_drained", 64'(issue_valid_o), 64'd0);

        // ---------------- full queue and backpressure ----------------
        // The first uop moves into the stalled issue register, so nine are
        // accepted (one issued + eight queued) and the tenth is refused.
        issue_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enq(6'(16 + k), 1'b1, 6'd0, 32'(16 + k), 1'b1, 6'd0, 32'(k));
            if (k == 9) begin
                check("full_enq_ready", 64'(enq_ready_o), 64'd0);
                check("full_count", 64'(count_o), 64'd8);
            end
            tick();
        end
        enq_off();                                                 // cycle 10
        check("full_count_hold", 64'(count_o), 64'd8);
        check("bp_valid_hold", 64'(issue_valid_o), 64'd1);
        check("bp_rob_hold", 64'(issue_rob_tag_o), 64'd16);
        check("bp_rs1_hold", 64'(issue_rs1_data_o), 64'd16);
        issue_ready_i = 1'b1;
        check("full_no_credit", 64'(enq_ready_o), 64'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("drain_rob", 64'(issue_rob_tag_o), 64'(17 + k));
            check("drain_count", 64'(count_o), 64'(7 - k));
            if (k == 0) begin
                check("drain_reopen", 64'(enq_ready_o), 64'd1);
            end
            tick();
        end
        check("drain_empty", 64'(issue_valid_o), 64'd0);

        // ---------------- enqueue bypass, lowest port wins ----------------
        enq(6'd30, 1'b0, 6'd12, 32'hDEAD, 1'b1, 6'd0, 32'h77);
        wb(2'b11, 6'd12, 32'h55, 6'd12, 32'h66);
        tick(); enq_off(); wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        check("byp_count_c1", 64'(count_o), 64'd1);
        tick();
        check("byp_valid_c2", 64'(issue_valid_o), 64'd1);
        check("byp_rob_c2", 64'(issue_rob_tag_o), 64'd30);
        check("byp_rs1_c2", 64'(issue_rs1_data_o), 64'h55);
        check("byp_rs2_c2", 64'(issue_rs2_data_o), 64'h77);
        tick();

        // ---------------- wakeup of an entry that shifts down ----------------
        issue_ready_i = 1'b0;
        enq(6'd33, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);         // filler into issue reg
        tick();
        enq(6'd34, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd2);         // slot 0
        tick();
        enq(6'd35, 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd3);        // slot 1, waits tag 50
        tick(); enq_off();
        issue_ready_i = 1'b1;
        wb(2'b01, 6'd50, 32'h50, 6'd0, 32'd0);
        check("shift_rob33", 64'(issue_rob_tag_o), 64'd33);
        check("shift_count2", 64'(count_o), 64'd2);
        tick(); wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        check("shift_rob34", 64'(issue_rob_tag_o), 64'd34);
        check("shift_count1", 64'(count_o), 64'd1);
        tick();
        check("shift_rob35", 64'(issue_rob_tag_o), 64'd35);
        check("shift_rs1", 64'(issue_rs1_data_o), 64'h50);
        check("shift_count0", 64'(count_o), 64'd0);
        tick();

        // ---------------- flush, then the same with reset ----------------
        for (int r = 0; r < 2; r++) begin
            issue_ready_i = 1'b0;
            for (int k = 0; k < 4; k++) begin
                enq(6'(40 + k), 1'b1, 6'd0, 32'(40 + k), 1'b1, 6'd0, 32'd9);
                tick();
            end
            enq(6'd44, 1'b1, 6'd0, 32'd44, 1'b1, 6'd0, 32'd44);
            if (r == 0) flush_i = 1'b1; else rst_i = 1'b1;
            check("pre_flush_count", 64'(count_o), 64'd3);
            check("pre_flush_valid", 64'(issue_valid_o), 64'd1);
            check("pre_flush_rob", 64'(issue_rob_tag_o), 64'd40);
            tick();
            flush_i = 1'b0; rst_i = 1'b0; enq_off();
            check(r == 0 ? "flush_count" : "rst_count2", 64'(count_o), 64'd0);
            check(r == 0 ? "flush_valid" : "rst_valid2", 64'(issue_valid_o), 64'd0);
            check(r == 0 ? "flush_enq_ready" : "rst_enq_ready2", 64'(enq_ready_o), 64'd1);
            if (r == 1) begin
                check("rst_rob_zero", 64'(issue_rob_tag_o), 64'd0);
                check("rst_rs1_zero", 64'(issue_rs1_data_o), 64'd0);
            end
            tick();
            check(r == 0 ? "flush_dropped_count" : "rst_dropped_count", 64'(count_o), 64'd0);
            check(r == 0 ? "flush_dropped_valid" : "rst_dropped_valid", 64'(issue_valid_o), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
